wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter ADR_W, default 30, word-address width of all ADR buses.
REQ-002 Parameter DAT_W, default 32, data width; SEL width is DAT_W/8.
REQ-003 Parameter TIMEOUT, default 255, maximum slave wait cycles before error; 0 disables the watchdog.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ibus_cyc_i, ibus_stb_i, ibus_we_i  input  1 each  instruction-master Wishbone classic controls.
REQ-007 ibus_adr_i  input  ADR_W; ibus_dat_i  input  DAT_W; ibus_sel_i  input  DAT_W/8  instruction-master request fields.
REQ-008 ibus_ack_o, ibus_err_o  output  1 each; ibus_dat_o  output  DAT_W  instruction-master response.
REQ-009 dbus_* ports identical to REQ-006..REQ-008 for the data master.
REQ-010 wbs_cyc_o, wbs_stb_o, wbs_we_o  output  1; wbs_adr_o  output  ADR_W; wbs_dat_o  output  DAT_W; wbs_sel_o  output  DAT_W/8  shared-slave request.
REQ-011 wbs_ack_i, wbs_err_i  input  1; wbs_dat_i  input  DAT_W  shared-slave response.
REQ-012 grant_o  output  2  current owner: 00 none, 01 ibus, 10 dbus.

Function
REQ-013 The arbiter SHALL implement a three-state FSM: IDLE, OWN_I, OWN_D.
REQ-014 In IDLE, all wbs_* outputs, all master ack/err and dat_o SHALL be 0, and grant_o SHALL be 00.
REQ-015 IDLE->OWN_I when only ibus_cyc_i is high; IDLE->OWN_D when only dbus_cyc_i is high; grant takes effect the next cycle (1-cycle arbitration latency).
REQ-016 When both cyc inputs are high in IDLE, the master not recorded in last_grant SHALL win (round-robin); last_grant resets to dbus, so ibus wins the first contest.
REQ-017 In OWN_x, wbs_cyc/stb/we/adr/dat/sel SHALL combinationally equal master x's inputs, and wbs_ack_i/err_i/dat_i SHALL route to master x only.
REQ-018 The non-owning master SHALL see ack=0, err=0, dat_o=0 at all times.
REQ-019 Ownership SHALL be held while the owner's cyc stays high, including across back-to-back STB cycles (no preemption).
REQ-020 When the owner drops cyc: if the other master's cyc is high, transition directly to OWN_other; else to IDLE; last_grant updates to the departing owner.
REQ-021 Watchdog counter SHALL increment each cycle wbs_cyc_o & wbs_stb_o are high with neither wbs_ack_i nor wbs_err_i, and clear on ack, err, or ownership change.
REQ-022 When the counter reaches TIMEOUT (TIMEOUT>0), the owner's err_o SHALL pulse high for exactly one cycle and the counter SHALL clear; the slave's ack in that same cycle takes precedence and suppresses the timeout err.
REQ-023 Simultaneous wbs_ack_i and wbs_err_i SHALL be forwarded unchanged.

Reset
REQ-024 reset high SHALL force IDLE, last_grant=dbus, and watchdog=0 at the next edge, aborting any in-flight cycle; all outputs then obey REQ-014.

Structure
REQ-025 FSM state encoding, grant_o encodings and default parameter values SHALL reside in a shared package wb_pkg.
REQ-026 The watchdog SHALL be one sub-module, wb_watchdog (count, clear, expire pulse).

Verification
REQ-027 Only ibus_cyc/stb high, adr=0x10; slave acks 2 cycles later -> grant_o=01 next cycle, wbs_adr_o=0x10, ibus_ack_o pulse, dbus_ack_o stays 0.
REQ-028 Both cyc high in IDLE after reset -> ibus granted first; ibus drops cyc -> dbus owns on the very next cycle; repeat contest -> dbus wins when last_grant=ibus.
REQ-029 dbus holds cyc for 4 back-to-back acked writes, ibus requesting throughout -> no handoff until dbus cyc falls.
REQ-030 TIMEOUT=4, slave never acks -> owner err_o high exactly in cycle 5 of stalled STB, one cycle wide.
REQ-031 reset asserted mid-transfer in OWN_D -> next cycle grant_o=00, wbs_cyc_o=0, dbus_ack_o=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings and defaults for the two-master Wishbone arbiter.
// FSM state values double as grant_o values.
package wb_pkg;

  localparam int ADR_W_DEF   = 30;
  localparam int DAT_W_DEF   = 32;
  localparam int TIMEOUT_DEF = 255;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_OWN_I = 2'b01;
  localparam logic [1:0] ST_OWN_D = 2'b10;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  // Round-robin pick from IDLE: on a contest the master
  // that did not own the bus last time wins.
  function automatic logic [1:0] rr_pick(
    input logic       i_cyc,
    input logic       d_cyc,
    input logic [1:0] last
  );
    logic [1:0] w_pick;
    w_pick = ST_IDLE;
    if (i_cyc && d_cyc)
      w_pick = (last == GNT_I) ? ST_OWN_D : ST_OWN_I;
    else if (i_cyc)
      w_pick = ST_OWN_I;
    else if (d_cyc)
      w_pick = ST_OWN_D;
    return w_pick;
  endfunction

  function automatic logic [1:0] state_to_grant(
    input logic [1:0] st
  );
    logic [1:0] w_g;
    w_g = GNT_NONE;
    if (st == ST_OWN_I)
      w_g = GNT_I;
    else if (st == ST_OWN_D)
      w_g = GNT_D;
    return w_g;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Slave-stall watchdog: counts unanswered strobe cycles and
// emits a one-cycle expire pulse when the limit is reached.
module wb_watchdog
  import wb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_active,
  input  logic i_ack,
  input  logic i_err,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic EN = (TIMEOUT != 0);

  logic [CW-1:0] r_cnt;
  logic          w_stall;

  assign w_stall = i_active & ~i_ack & ~i_err;

  // A slave ack/err in the limit cycle masks the expiry.
  assign o_expire = EN & w_stall & (r_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear | i_ack | i_err | o_expire) begin
      r_cnt <= '0;
    end else if (w_stall & EN) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master (ibus/dbus) to one-slave Wishbone classic arbiter
// with round-robin grant, no preemption and a stall watchdog.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int ADR_W   = ADR_W_DEF,
  parameter int DAT_W   = DAT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               ibus_cyc_i,
  input  logic               ibus_stb_i,
  input  logic               ibus_we_i,
  input  logic [ADR_W-1:0]   ibus_adr_i,
  input  logic [DAT_W-1:0]   ibus_dat_i,
  input  logic [DAT_W/8-1:0] ibus_sel_i,
  output logic               ibus_ack_o,
  output logic               ibus_err_o,
  output logic [DAT_W-1:0]   ibus_dat_o,

  input  logic               dbus_cyc_i,
  input  logic               dbus_stb_i,
  input  logic               dbus_we_i,
  input  logic [ADR_W-1:0]   dbus_adr_i,
  input  logic [DAT_W-1:0]   dbus_dat_i,
  input  logic [DAT_W/8-1:0] dbus_sel_i,
  output logic               dbus_ack_o,
  output logic               dbus_err_o,
  output logic [DAT_W-1:0]   dbus_dat_o,

  output logic               wbs_cyc_o,
  output logic               wbs_stb_o,
  output logic               wbs_we_o,
  output logic [ADR_W-1:0]   wbs_adr_o,
  output logic [DAT_W-1:0]   wbs_dat_o,
  output logic [DAT_W/8-1:0] wbs_sel_o,
  input  logic               wbs_ack_i,
  input  logic               wbs_err_i,
  input  logic [DAT_W-1:0]   wbs_dat_i,

  output logic [1:0]         grant_o
);

  logic [1:0] r_state;
  logic [1:0] r_last;
  logic [1:0] w_state_nxt;
  logic [1:0] w_last_nxt;
  logic       w_i_own;
  logic       w_d_own;
  logic       w_active;
  logic       w_expire;
  logic       w_handoff;

  assign w_i_own = (r_state == ST_OWN_I);
  assign w_d_own = (r_state == ST_OWN_D);
  assign grant_o = state_to_grant(r_state);

  // Owner keeps the bus until its own cyc falls.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    unique case (1'b1)
      w_i_own: begin
        if (!ibus_cyc_i) begin
          w_last_nxt  = GNT_I;
          w_state_nxt = dbus_cyc_i ? ST_OWN_D : ST_IDLE;
        end
      end
      w_d_own: begin
        if (!dbus_cyc_i) begin
          w_last_nxt  = GNT_D;
          w_state_nxt = ibus_cyc_i ? ST_OWN_I : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = rr_pick(ibus_cyc_i, dbus_cyc_i, r_last);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_last  <= GNT_D;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign w_handoff = (w_state_nxt != r_state);

  always_comb begin
    w_active = 1'b0;
    unique case (1'b1)
      w_i_own: w_active = ibus_cyc_i & ibus_stb_i;
      w_d_own: w_active = dbus_cyc_i & dbus_stb_i;
      default: w_active = 1'b0;
    endcase
  end

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .i_active (w_active),
    .i_ack    (wbs_ack_i),
    .i_err    (wbs_err_i),
    .i_clear  (w_handoff),
    .o_expire (w_expire)
  );

  // Request path: mirror the owner, zero when idle.
  always_comb begin
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_we_o  = 1'b0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    unique case (1'b1)
      w_i_own: begin
        wbs_cyc_o = ibus_cyc_i;
        wbs_stb_o = ibus_stb_i;
        wbs_we_o  = ibus_we_i;
        wbs_adr_o = ibus_adr_i;
        wbs_dat_o = ibus_dat_i;
        wbs_sel_o = ibus_sel_i;
      end
      w_d_own: begin
        wbs_cyc_o = dbus_cyc_i;
        wbs_stb_o = dbus_stb_i;
        wbs_we_o  = dbus_we_i;
        wbs_adr_o = dbus_adr_i;
        wbs_dat_o = dbus_dat_i;
        wbs_sel_o = dbus_sel_i;
      end
      default: begin
      end
    endcase
  end

  // Response path: only the owner ever sees the slave.
  always_comb begin
    ibus_ack_o = 1'b0;
    ibus_err_o = 1'b0;
    ibus_dat_o = '0;
    dbus_ack_o = 1'b0;
    dbus_err_o = 1'b0;
    dbus_dat_o = '0;
    unique case (1'b1)
      w_i_own: begin
        ibus_ack_o = wbs_ack_i;
        ibus_err_o = wbs_err_i | w_expire;
        ibus_dat_o = wbs_dat_i;
      end
      w_d_own: begin
        dbus_ack_o = wbs_ack_i;
        dbus_err_o = wbs_err_i | w_expire;
        dbus_dat_o = wbs_dat_i;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a per-cycle reference model
// queues expected outputs, a negedge monitor compares them.
module tb_wb_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ibus_cyc_i, ibus_stb_i, ibus_we_i;
  logic [AW-1:0] ibus_adr_i;
  logic [DW-1:0] ibus_dat_i;
  logic [SW-1:0] ibus_sel_i;
  logic          ibus_ack_o, ibus_err_o;
  logic [DW-1:0] ibus_dat_o;
  logic          dbus_cyc_i, dbus_stb_i, dbus_we_i;
  logic [AW-1:0] dbus_adr_i;
  logic [DW-1:0] dbus_dat_i;
  logic [SW-1:0] dbus_sel_i;
  logic          dbus_ack_o, dbus_err_o;
  logic [DW-1:0] dbus_dat_o;
  logic          wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [AW-1:0] wbs_adr_o;
  logic [DW-1:0] wbs_dat_o;
  logic [SW-1:0] wbs_sel_o;
  logic          wbs_ack_i, wbs_err_i;
  logic [DW-1:0] wbs_dat_i;
  logic [1:0]    grant_o;

  always #5 clk = ~clk;

  wb_arbiter #(
    .ADR_W   (AW),
    .DAT_W   (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ibus_cyc_i (ibus_cyc_i),
    .ibus_stb_i (ibus_stb_i),
    .ibus_we_i  (ibus_we_i),
    .ibus_adr_i (ibus_adr_i),
    .ibus_dat_i (ibus_dat_i),
    .ibus_sel_i (ibus_sel_i),
    .ibus_ack_o (ibus_ack_o),
    .ibus_err_o (ibus_err_o),
    .ibus_dat_o (ibus_dat_o),
    .dbus_cyc_i (dbus_cyc_i),
    .dbus_stb_i (dbus_stb_i),
    .dbus_we_i  (dbus_we_i),
    .dbus_adr_i (dbus_adr_i),
    .dbus_dat_i (dbus_dat_i),
    .dbus_sel_i (dbus_sel_i),
    .dbus_ack_o (dbus_ack_o),
    .dbus_err_o (dbus_err_o),
    .dbus_dat_o (dbus_dat_o),
    .wbs_cyc_o  (wbs_cyc_o),
    .wbs_stb_o  (wbs_stb_o),
    .wbs_we_o   (wbs_we_o),
    .wbs_adr_o  (wbs_adr_o),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_sel_o  (wbs_sel_o),
    .wbs_ack_i  (wbs_ack_i),
    .wbs_err_i  (wbs_err_i),
    .wbs_dat_i  (wbs_dat_i),
    .grant_o    (grant_o)
  );

  typedef struct {
    logic [1:0]    gnt;
    logic          cyc, stb, we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic          iack, ierr;
    logic [DW-1:0] idat;
    logic          dack, derr;
    logic [DW-1:0] ddat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: owner 0=none 1=ibus 2=dbus.
  int m_own    = 0;
  int m_last   = 2;
  int m_waited = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: dut=%0h model=%0h t=%0t",
               nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("grant",    64'(grant_o),    64'(e.gnt));
      chk("wbs_cyc",  64'(wbs_cyc_o),  64'(e.cyc));
      chk("wbs_stb",  64'(wbs_stb_o),  64'(e.stb));
      chk("wbs_we",   64'(wbs_we_o),   64'(e.we));
      chk("wbs_adr",  64'(wbs_adr_o),  64'(e.adr));
      chk("wbs_dat",  64'(wbs_dat_o),  64'(e.dat));
      chk("wbs_sel",  64'(wbs_sel_o),  64'(e.sel));
      chk("ibus_ack", 64'(ibus_ack_o), 64'(e.iack));
      chk("ibus_err", 64'(ibus_err_o), 64'(e.ierr));
      chk("ibus_dat", 64'(ibus_dat_o), 64'(e.idat));
      chk("dbus_ack", 64'(dbus_ack_o), 64'(e.dack));
      chk("dbus_err", 64'(dbus_err_o), 64'(e.derr));
      chk("dbus_dat", 64'(dbus_dat_o), 64'(e.ddat));
    end
  end

  // Called at posedge+1 with control inputs set: predicts this
  // cycle's outputs, advances the model, moves to next posedge+1.
  task automatic go();
    exp_t e;
    bit   mc, ms, busy, tmo, ocyc;
    int   nown;
    ibus_dat_i = $urandom;
    dbus_dat_i = $urandom;
    wbs_dat_i  = $urandom;
    ibus_sel_i = SW'($urandom);
    dbus_sel_i = SW'($urandom);
    e = '{default: '0};
    mc = (m_own == 1) ? ibus_cyc_i : dbus_cyc_i;
    ms = (m_own == 1) ? ibus_stb_i : dbus_stb_i;
    busy = (m_own != 0) && mc && ms;
    tmo = busy && !wbs_ack_i && !wbs_err_i
          && (m_waited == TO);
    if (m_own == 1) begin
      e.gnt = 2'b01;
      e.cyc = ibus_cyc_i; e.stb = ibus_stb_i;
      e.we  = ibus_we_i;  e.adr = ibus_adr_i;
      e.dat = ibus_dat_i; e.sel = ibus_sel_i;
      e.iack = wbs_ack_i;
      e.ierr = wbs_err_i | tmo;
      e.idat = wbs_dat_i;
    end else if (m_own == 2) begin
      e.gnt = 2'b10;
      e.cyc = dbus_cyc_i; e.stb = dbus_stb_i;
      e.we  = dbus_we_i;  e.adr = dbus_adr_i;
      e.dat = dbus_dat_i; e.sel = dbus_sel_i;
      e.dack = wbs_ack_i;
      e.derr = wbs_err_i | tmo;
      e.ddat = wbs_dat_i;
    end
    exp_q.push_back(e);
    if (reset) begin
      m_own = 0; m_last = 2; m_waited = 0;
    end else begin
      if (m_own == 0) begin
        if (ibus_cyc_i && dbus_cyc_i)
          nown = (m_last == 1) ? 2 : 1;
        else if (ibus_cyc_i) nown = 1;
        else if (dbus_cyc_i) nown = 2;
        else nown = 0;
      end else if (!mc) begin
        m_last = m_own;
        ocyc = (m_own == 1) ? dbus_cyc_i : ibus_cyc_i;
        nown = ocyc ? 3 - m_own : 0;
      end else begin
        nown = m_own;
      end
      if (nown != m_own || tmo || wbs_ack_i || wbs_err_i)
        m_waited = 0;
      else if (busy)
        m_waited++;
      m_own = nown;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_i(input bit c, input bit s,
                       input logic [AW-1:0] a);
    ibus_cyc_i = c; ibus_stb_i = s; ibus_adr_i = a;
  endtask

  task automatic set_d(input bit c, input bit s,
                       input logic [AW-1:0] a);
    dbus_cyc_i = c; dbus_stb_i = s; dbus_adr_i = a;
  endtask

  task automatic set_s(input bit a, input bit e);
    wbs_ack_i = a; wbs_err_i = e;
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    set_i(0, 0, '0); set_d(0, 0, '0); set_s(0, 0);
    ibus_we_i = 0; dbus_we_i = 0;
    ibus_dat_i = '0; dbus_dat_i = '0; wbs_dat_i = '0;
    ibus_sel_i = '0; dbus_sel_i = '0;
    repeat (2) @(posedge clk);
    #1;
    go();
    reset = 1'b0;
    go();

    // Single ibus read at 0x10, slave acks two cycles in.
    set_i(1, 1, AW'(32'h10));
    go(); go(); go();
    set_s(1, 0); go();
    set_s(0, 0); set_i(0, 0, '0); go(); go();

    // Contest, handoff, and round-robin on repeat contests.
    set_s(1, 0);
    set_i(1, 1, AW'(32'h20)); set_d(1, 1, AW'(32'h30));
    go(); go();
    set_i(0, 0, '0); go(); go();
    set_d(0, 0, '0); go();
    set_i(1, 1, AW'(32'h21)); set_d(1, 1, AW'(32'h31));
    go(); go();
    set_d(0, 0, '0); go();
    set_i(0, 0, '0); go();
    set_i(1, 1, AW'(32'h22)); set_d(1, 1, AW'(32'h32));
    go(); go(); go();
    set_i(0, 0, '0); set_d(0, 0, '0); go(); go();

    // dbus keeps the bus over 4 acked writes.
    dbus_we_i = 1;
    set_s(0, 0); set_d(1, 0, AW'(32'h40)); go();
    set_i(1, 1, AW'(32'h50));
    for (int k = 0; k < 4; k++) begin
      set_d(1, 1, AW'(32'h40 + k)); set_s(1, 0); go();
    end
    set_s(0, 0); set_d(0, 0, '0); go();
    go(); set_i(0, 0, '0); go(); go();
    dbus_we_i = 0;

    // Stalled slave: periodic timeout, ack masking, ack+err.
    set_d(1, 1, AW'(32'h60)); go();
    repeat (11) go();
    set_d(0, 0, '0); go();
    set_d(1, 1, AW'(32'h61)); go();
    repeat (4) go();
    set_s(1, 0); go();
    set_s(1, 1); go();
    set_s(0, 0); repeat (3) go();
    set_s(0, 1); go();
    set_s(0, 0); set_d(0, 0, '0); go();

    // Reset in the middle of a dbus transfer.
    set_d(1, 1, AW'(32'h70)); go(); go();
    reset = 1'b1; go();
    reset = 1'b0; go();
    set_d(0, 0, '0); go(); go();

    // Randomized traffic, slave responsiveness per block.
    for (int blk = 0; blk < 10; blk++) begin
      for (int n = 0; n < 200; n++) begin
        if ($urandom_range(7) == 0) ibus_cyc_i = ~ibus_cyc_i;
        if ($urandom_range(7) == 0) dbus_cyc_i = ~dbus_cyc_i;
        ibus_stb_i = ibus_cyc_i & ($urandom_range(3) != 0);
        dbus_stb_i = dbus_cyc_i & ($urandom_range(3) != 0);
        ibus_we_i  = 1'($urandom);
        dbus_we_i  = 1'($urandom);
        ibus_adr_i = AW'($urandom);
        dbus_adr_i = AW'($urandom);
        wbs_ack_i  = ($urandom_range(99) < blk * 10);
        wbs_err_i  = ($urandom_range(99) < 5);
        reset      = ($urandom_range(299) == 0);
        go();
      end
    end
    reset = 1'b0;

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
